// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
package tdm_pkg;

   // Frame-alignment state: HUNT waits for a sync, COLLECT assembles frames.
   typedef enum logic {
      HUNT,
      COLLECT
   } state_t;

   localparam int N_CH_DEF = 4;
   localparam int DW_DEF   = 8;

endpackage

// File: rtl/demux_dec.sv
// 1:N_CH write-enable decoder: one-hot enable for the addressed slot.
module demux_dec
   import tdm_pkg::*;
#(
   parameter  int N_CH = N_CH_DEF,
   localparam int SW   = $clog2(N_CH)
) (
   input  logic [SW-1:0]   slot,
   input  logic            en,
   output logic [N_CH-1:0] we
);

   // Raise exactly the enable matching slot while en is high.
   always_comb begin
      we = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         we[k] = en && (slot == SW'(k));
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: collects N_CH serial samples per sync-marked frame,
// publishes complete frames atomically and re-acquires lost alignment.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter  int N_CH = N_CH_DEF,
   parameter  int DW   = DW_DEF,
   localparam int SW   = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DW-1:0]        din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   output logic [N_CH*DW-1:0]   dout,
   output logic                 dout_valid,
   output logic [SW-1:0]        slot,
   output logic                 locked,
   output logic                 sync_err
);

   localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
   localparam logic [SW-1:0] ONE       = SW'(1);

   state_t                    state_q, state_d;
   logic [SW-1:0]             slot_q, slot_d;
   logic [N_CH-2:0][DW-1:0]   shadow_q, shadow_d;
   logic [N_CH*DW-1:0]        dout_q, dout_d;
   logic                      dout_valid_q, dout_valid_d;
   logic                      sync_err_q, sync_err_d;

   logic                      wr_en;
   logic [SW-1:0]             wr_slot;
   logic [N_CH-1:0]           we;

   // Decoder output k<N_CH-1 enables shadow[k]; the top enable marks the
   // final sample, which goes straight to dout together with the shadows.
   demux_dec #(
      .N_CH (N_CH)
   ) u_dec (
      .slot (wr_slot),
      .en   (wr_en),
      .we   (we)
   );

   // Next-state, slot and pulse logic for each accepted beat.
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      wr_en        = 1'b0;
      wr_slot      = '0;
      dout_valid_d = 1'b0;
      sync_err_d   = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  wr_en   = 1'b1;
                  slot_d  = ONE;
                  state_d = COLLECT;
               end
            end
            COLLECT: begin
               if (frame_sync) begin
                  // A sync always restarts the frame; only mid-frame is an error.
                  sync_err_d = (slot_q != '0);
                  wr_en      = 1'b1;
                  slot_d     = ONE;
               end else if (slot_q == '0) begin
                  sync_err_d = 1'b1;
                  slot_d     = '0;
                  state_d    = HUNT;
               end else begin
                  wr_en   = 1'b1;
                  wr_slot = slot_q;
                  if (slot_q == LAST_SLOT) begin
                     slot_d       = '0;
                     dout_valid_d = 1'b1;
                  end else begin
                     slot_d = slot_q + ONE;
                  end
               end
            end
            default: begin
               state_d = HUNT;
               slot_d  = '0;
            end
         endcase
      end
   end

   // Shadow writes for channels 0..N_CH-2.
   always_comb begin
      shadow_d = shadow_q;
      for (int unsigned k = 0; k < N_CH - 1; k++) begin
         if (we[k]) begin
            shadow_d[k] = din;
         end
      end
   end

   // Output frame assembly on the last sample of a frame.
   always_comb begin
      dout_d = dout_q;
      if (we[N_CH-1]) begin
         for (int unsigned k = 0; k < N_CH - 1; k++) begin
            dout_d[k*DW +: DW] = shadow_q[k];
         end
         dout_d[(N_CH-1)*DW +: DW] = din;
      end
   end

   // State, slot, shadow and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= HUNT;
         slot_q       <= '0;
         shadow_q     <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         shadow_q     <= shadow_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign slot       = slot_q;
   assign locked     = (state_q == COLLECT);
   assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based frame model.
module tb_tdm_demux;

   localparam int N_CH = 4;
   localparam int DW   = 8;
   localparam int SW   = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [DW-1:0]       din;
   logic                din_valid;
   logic                frame_sync;
   logic [N_CH*DW-1:0]  dout;
   logic                dout_valid;
   logic [SW-1:0]       slot;
   logic                locked;
   logic                sync_err;

   tdm_demux #(
      .N_CH (N_CH),
      .DW   (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .frame_sync (frame_sync),
      .dout       (dout),
      .dout_valid (dout_valid),
      .slot       (slot),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a frame is a queue of samples received since the sync.
   bit                 m_locked;
   logic [DW-1:0]      m_q[$];
   logic [N_CH*DW-1:0] m_dout;
   bit                 m_dv;
   bit                 m_err;

   function automatic void model_reset();
      m_locked = 1'b0;
      m_q.delete();
      m_dout   = '0;
      m_dv     = 1'b0;
      m_err    = 1'b0;
   endfunction

   function automatic void model_beat(bit v, bit s, logic [DW-1:0] d);
      m_dv  = 1'b0;
      m_err = 1'b0;
      if (!v) return;
      if (!m_locked) begin
         if (s) begin
            m_locked = 1'b1;
            m_q.delete();
            m_q.push_back(d);
         end
      end else if (s) begin
         if (m_q.size() != 0) m_err = 1'b1;
         m_q.delete();
         m_q.push_back(d);
      end else if (m_q.size() == 0) begin
         m_err    = 1'b1;
         m_locked = 1'b0;
      end else begin
         m_q.push_back(d);
         if (m_q.size() == N_CH) begin
            for (int k = 0; k < N_CH; k++) m_dout[k*DW +: DW] = m_q[k];
            m_dv = 1'b1;
            m_q.delete();
         end
      end
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".dout"},       64'(dout),       64'(m_dout));
      chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(m_dv));
      chk({tag, ".sync_err"},   64'(sync_err),   64'(m_err));
      chk({tag, ".slot"},       64'(slot),       64'(m_q.size()));
      chk({tag, ".locked"},     64'(locked),     64'(m_locked));
   endtask

   // Present one beat for one clock edge; outputs settle #1 after the edge.
   task automatic drive(input bit v, input bit s, input logic [DW-1:0] d);
      din_valid  = v;
      frame_sync = s;
      din        = d;
      model_beat(v, s, d);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      din        = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("reset.dout",       64'(dout),       64'h0);
      chk("reset.dout_valid", 64'(dout_valid), 64'h0);
      chk("reset.slot",       64'(slot),       64'h0);
      chk("reset.locked",     64'(locked),     64'h0);
      chk("reset.sync_err",   64'(sync_err),   64'h0);
      rst = 1'b0;
   endtask

   typedef struct {
      bit          v;
      bit          s;
      logic [7:0]  d;
      logic [31:0] dout;
      bit          dv;
      bit          err;
      int          slot;
      bit          lk;
      string       name;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit v, bit s, logic [7:0] d, logic [31:0] o,
                               bit dv, bit err, int sl, bit lk, string name);
      vec_t e;
      e.v = v; e.s = s; e.d = d; e.dout = o; e.dv = dv;
      e.err = err; e.slot = sl; e.lk = lk; e.name = name;
      tbl.push_back(e);
   endfunction

   int dv_cnt;

   initial begin
      rst = 1'b1;

      // Aligned frame, early sync, missing sync and re-lock.
      add(1, 1, 8'hA0, 32'h0,        0, 0, 1, 1, "al.A0");
      add(1, 0, 8'hB1, 32'h0,        0, 0, 2, 1, "al.B1");
      add(1, 0, 8'hC2, 32'h0,        0, 0, 3, 1, "al.C2");
      add(1, 0, 8'hD3, 32'hD3C2B1A0, 1, 0, 0, 1, "al.D3");
      add(0, 0, 8'hEE, 32'hD3C2B1A0, 0, 0, 0, 1, "al.idle");
      add(1, 1, 8'h11, 32'hD3C2B1A0, 0, 0, 1, 1, "es.11");
      add(1, 0, 8'h22, 32'hD3C2B1A0, 0, 0, 2, 1, "es.22");
      add(1, 1, 8'h33, 32'hD3C2B1A0, 0, 1, 1, 1, "es.33");
      add(1, 0, 8'h44, 32'hD3C2B1A0, 0, 0, 2, 1, "es.44");
      add(1, 0, 8'h55, 32'hD3C2B1A0, 0, 0, 3, 1, "es.55");
      add(1, 0, 8'h66, 32'h66554433, 1, 0, 0, 1, "es.66");
      add(1, 0, 8'h77, 32'h66554433, 0, 1, 0, 0, "ms.77");
      add(1, 0, 8'h78, 32'h66554433, 0, 0, 0, 0, "ms.hunt");
      add(1, 1, 8'h01, 32'h66554433, 0, 0, 1, 1, "rl.01");
      add(1, 0, 8'h02, 32'h66554433, 0, 0, 2, 1, "rl.02");
      add(1, 0, 8'h03, 32'h66554433, 0, 0, 3, 1, "rl.03");
      add(1, 0, 8'h04, 32'h04030201, 1, 0, 0, 1, "rl.04");

      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d);
         chk({tbl[i].name, ".dout"},       64'(dout),       64'(tbl[i].dout));
         chk({tbl[i].name, ".dout_valid"}, 64'(dout_valid), 64'(tbl[i].dv));
         chk({tbl[i].name, ".sync_err"},   64'(sync_err),   64'(tbl[i].err));
         chk({tbl[i].name, ".slot"},       64'(slot),       64'(tbl[i].slot));
         chk({tbl[i].name, ".locked"},     64'(locked),     64'(tbl[i].lk));
      end

      // HUNT discard: unsynced beats after reset change nothing.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 8'(8'h90 + i));
         chk("hunt.dout",       64'(dout),       64'h0);
         chk("hunt.dout_valid", 64'(dout_valid), 64'h0);
         chk("hunt.sync_err",   64'(sync_err),   64'h0);
         chk("hunt.locked",     64'(locked),     64'h0);
      end

      // Gaps: 3 idle cycles between beats, slot holds, one dout_valid.
      dv_cnt = 0;
      begin
         logic [7:0] g[4];
         g[0] = 8'hA0; g[1] = 8'hB1; g[2] = 8'hC2; g[3] = 8'hD3;
         for (int i = 0; i < 4; i++) begin
            drive(1, i == 0, g[i]);
            if (dout_valid) dv_cnt++;
            chk_model("gap.beat");
            for (int j = 0; j < 3; j++) begin
               drive(0, 0, 8'hFF);
               if (dout_valid) dv_cnt++;
               chk("gap.slot", 64'(slot), 64'((i + 1) % N_CH));
            end
         end
      end
      chk("gap.dout",     64'(dout),   64'hD3C2B1A0);
      chk("gap.dv_count", 64'(dv_cnt), 64'd1);

      // Mid-frame reset: outputs clear without waiting for a clock edge.
      drive(1, 1, 8'h5A);
      drive(1, 0, 8'h5B);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst.dout",       64'(dout),       64'h0);
      chk("mrst.dout_valid", 64'(dout_valid), 64'h0);
      chk("mrst.slot",       64'(slot),       64'h0);
      chk("mrst.locked",     64'(locked),     64'h0);
      chk("mrst.sync_err",   64'(sync_err),   64'h0);
      model_reset();
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 0, 8'h5C);
      chk_model("mrst.hunt");
      drive(1, 1, 8'hC0);
      drive(1, 0, 8'hC1);
      drive(1, 0, 8'hC2);
      drive(1, 0, 8'hC3);
      chk("mrst.frame", 64'(dout), 64'hC3C2C1C0);
      chk_model("mrst.after");

      // Full-rate back-to-back frames: one pulse every N_CH cycles.
      dv_cnt = 0;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N_CH; i++) begin
            drive(1, i == 0, 8'(f * 16 + i));
            if (dout_valid) dv_cnt++;
            chk("b2b.dout_valid", 64'(dout_valid), 64'(i == N_CH - 1));
         end
      end
      chk("b2b.count", 64'(dv_cnt), 64'd3);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 8'($urandom));
         chk_model("rand");
         chk("rand.exclusive", 64'(dout_valid & sync_err), 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
